regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//  Y86 program register file: eight 32-bit registers %eax..%edi.
//  Consumes the writeback stage outputs (wb_dstE/wb_valE, wb_dstM/wb_valM)
//  and writes them on the clock edge.
//  Serves the decode stage through two combinational read ports (srcA, srcB).
//  Optional write-through bypass lets decode see a same-cycle writeback.
// PARAMETERS
//  STACK_INIT  32'h0000_0100  reset value of %esp (ID 4)
//  BYPASS      1              1: a read of a register being written this cycle returns the new value; 0: returns the stored value
// PORTS
//  clk       input   1       clock; all state changes on posedge
//  rst       input   1       reset, synchronous, active-low (rst==0 resets)
//  wb_stall  input   1       1: suppress both writes this cycle (bubble in WB)
//  wb_dstE   input   `BYTE   E-port destination ID; 4'hf = none
//  wb_valE   input   `WORD   E-port write data
//  wb_dstM   input   `BYTE   M-port destination ID; 4'hf = none
//  wb_valM   input   `WORD   M-port write data
//  id_srcA   input   `BYTE   read port A register ID; 4'hf = none
//  id_srcB   input   `BYTE   read port B register ID; 4'hf = none
//  id_valA   output  `WORD   read port A data
//  id_valB   output  `WORD   read port B data
// BEHAVIOUR
//  - Register IDs: 0 eax, 1 ecx, 2 edx, 3 ebx, 4 esp, 5 ebp, 6 esi, 7 edi.
//    Only ID[3:0] is decoded; bits above [3] are ignored.
//  - IDs 8..14 are invalid and 15 is RNONE:
//    - a write to them is dropped;
//    - a read of them returns 32'h0.
//  - Reset: on posedge clk with rst==0, regs 0..3 and 5..7 <= 0 and reg 4 <= STACK_INIT.
//    Writes are ignored during a reset cycle; reset overrides wb_stall and all write ports.
//  - Write: on posedge clk with rst==1 and wb_stall==0:
//    - reg[wb_dstE] <= wb_valE if dstE is valid;
//    - reg[wb_dstM] <= wb_valM if dstM is valid;
//    - both ports write in the same cycle when their IDs differ.
//  - Collision: if dstE==dstM (valid), the M port wins: reg <= wb_valM.
//    This gives the correct result for popl %esp.
//  - Latency: a write is visible in the array one cycle later.
//    Reads are combinational, with zero cycles from id_src* to id_val*.
//  - BYPASS=1, for each read port with a valid src, in priority order:
//    1. src==wb_dstM (valid) and !wb_stall: return wb_valM;
//    2. else src==wb_dstE (valid) and !wb_stall: return wb_valE;
//    3. else return the stored value.
//    Bypass is disabled while rst==0; reads during reset return stored contents.
//  - BYPASS=0: reads always return stored contents.
//    A same-cycle write appears on the read port after the edge.
//  - Both read ports are independent; srcA==srcB returns the same value on both.
//  - No other state. Outputs are pure functions of the array and the inputs, so no output reset value is needed.
//    After reset: id_val* = 0 for IDs 0..3 and 5..7, STACK_INIT for ID 4.
// TESTING
//  1. Reset, then read every ID 0..15 -> 0 except ID4=32'h100; IDs 8..15 read 0.
//  2. dstE=0, valE=32'hDEAD_BEEF, dstM=3, valM=32'h1234_5678, one edge
//     -> reg0=DEADBEEF, reg3=12345678, all others unchanged.
//  3. dstE=dstM=4, valE=32'h0FC, valM=32'hCAFE -> reg4=32'hCAFE (M priority).
//  4. BYPASS=1: srcA=2, dstE=2, valE=32'h55 in the same cycle -> id_valA=32'h55 before the edge.
//     Repeat with BYPASS=0 -> old value before the edge, 32'h55 after.
//  5. wb_stall=1, dstE=1, valE=32'hFFFF_FFFF -> reg1 unchanged; with BYPASS=1, srcB=1 gives the stored value.
//  6. Write reg5=32'hAA, then rst=0 for one cycle with dstE=5, valE=32'h77
//     -> reg5=0 (reset wins); then dstE=9 and dstM=15 writes change no register.

Source files
------------

// File: rtl/regfile.sv
// Y86 program register file: eight 32-bit registers, two write ports (E, M)
// from writeback, two combinational read ports for decode, optional bypass.
module regfile #(
    parameter logic [31:0] STACK_INIT = 32'h0000_0100,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stall,
    input  logic [7:0]  wb_dstE,
    input  logic [31:0] wb_valE,
    input  logic [7:0]  wb_dstM,
    input  logic [31:0] wb_valM,
    input  logic [7:0]  id_srcA,
    input  logic [7:0]  id_srcB,
    output logic [31:0] id_valA,
    output logic [31:0] id_valB
);

    logic [31:0] r_regs [0:7];

    logic w_weE;
    logic w_weM;
    logic w_byp;
    logic w_unused_hi;

    // IDs 8..15 have bit 3 set: invalid or RNONE, never written or read.
    assign w_weE = ~wb_stall & ~wb_dstE[3];
    assign w_weM = ~wb_stall & ~wb_dstM[3];
    assign w_byp = BYPASS & rst;

    assign w_unused_hi = ^{wb_dstE[7:4], wb_dstM[7:4],
                           id_srcA[7:4], id_srcB[7:4]};

    // M write is issued last so it wins a dstE==dstM collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= (i == 4) ? STACK_INIT : 32'h0;
            end
        end else begin
            if (w_weE) r_regs[wb_dstE[2:0]] <= wb_valE;
            if (w_weM) r_regs[wb_dstM[2:0]] <= wb_valM;
        end
    end

    function automatic logic [31:0] rd_port(input logic [3:0] src);
        logic [31:0] v;
        v = 32'h0;
        if (!src[3]) begin
            if (w_byp && w_weM && (src == wb_dstM[3:0])) begin
                v = wb_valM;
            end else if (w_byp && w_weE && (src == wb_dstE[3:0])) begin
                v = wb_valE;
            end else begin
                v = r_regs[src[2:0]];
            end
        end
        return v;
    endfunction

    always_comb begin
        id_valA = rd_port(id_srcA[3:0]);
        id_valB = rd_port(id_srcB[3:0]);
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: one bypassing and one non-bypassing instance
// share the same stimulus; checks use immediate assertions.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_stall;
    logic [7:0]  wb_dstE;
    logic [31:0] wb_valE;
    logic [7:0]  wb_dstM;
    logic [31:0] wb_valM;
    logic [7:0]  id_srcA;
    logic [7:0]  id_srcB;
    logic [31:0] b1_valA;
    logic [31:0] b1_valB;
    logic [31:0] b0_valA;
    logic [31:0] b0_valB;

    int checks;
    int failures;

    regfile #(.STACK_INIT(32'h0000_0100), .BYPASS(1'b1)) u_b1 (
        .clk      (clk),
        .rst      (rst),
        .wb_stall (wb_stall),
        .wb_dstE  (wb_dstE),
        .wb_valE  (wb_valE),
        .wb_dstM  (wb_dstM),
        .wb_valM  (wb_valM),
        .id_srcA  (id_srcA),
        .id_srcB  (id_srcB),
        .id_valA  (b1_valA),
        .id_valB  (b1_valB)
    );

    regfile #(.STACK_INIT(32'h0000_0100), .BYPASS(1'b0)) u_b0 (
        .clk      (clk),
        .rst      (rst),
        .wb_stall (wb_stall),
        .wb_dstE  (wb_dstE),
        .wb_valE  (wb_valE),
        .wb_dstM  (wb_dstM),
        .wb_valM  (wb_valM),
        .id_srcA  (id_srcA),
        .id_srcB  (id_srcB),
        .id_valA  (b0_valA),
        .id_valB  (b0_valB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_wr();
        wb_stall = 1'b0;
        wb_dstE  = 8'h0f;
        wb_valE  = 32'h0;
        wb_dstM  = 8'h0f;
        wb_valM  = 32'h0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] b);
        id_srcA = a;
        id_srcB = b;
        #1;
    endtask

    // Apply an edge and return on the following negedge.
    task automatic edge_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle_wr();
        id_srcA  = 8'h0f;
        id_srcB  = 8'h0f;

        // 1: reset, read every ID on both ports and both instances
        @(negedge clk);
        edge_cycle();
        rst = 1'b1;
        for (int id = 0; id < 16; id++) begin
            rd(8'(id), 8'(id));
            chk($sformatf("rst_A_id%0d", id), b1_valA,
                (id == 4) ? 32'h100 : 32'h0);
            chk($sformatf("rst_B0_id%0d", id), b0_valB,
                (id == 4) ? 32'h100 : 32'h0);
        end

        // 2: dual write to different registers
        wb_dstE = 8'h00; wb_valE = 32'hDEAD_BEEF;
        wb_dstM = 8'h03; wb_valM = 32'h1234_5678;
        edge_cycle();
        idle_wr();
        rd(8'h00, 8'h03);
        chk("dual_reg0", b1_valA, 32'hDEAD_BEEF);
        chk("dual_reg3", b1_valB, 32'h1234_5678);
        rd(8'h01, 8'h04);
        chk("dual_reg1", b0_valA, 32'h0);
        chk("dual_reg4", b0_valB, 32'h100);
        rd(8'h13, 8'h70);
        chk("hi_bits_src3", b1_valA, 32'h1234_5678);
        chk("hi_bits_src0", b0_valB, 32'hDEAD_BEEF);

        // 3: same destination, M port wins
        wb_dstE = 8'h04; wb_valE = 32'h0FC;
        wb_dstM = 8'h04; wb_valM = 32'hCAFE;
        edge_cycle();
        idle_wr();
        rd(8'h04, 8'h04);
        chk("coll_b1", b1_valA, 32'hCAFE);
        chk("coll_b0", b0_valB, 32'hCAFE);

        // 4: same-cycle write-through vs stored value
        wb_dstE = 8'h02; wb_valE = 32'h55;
        rd(8'h02, 8'h0f);
        chk("byp1_pre", b1_valA, 32'h55);
        chk("byp0_pre", b0_valA, 32'h0);
        chk("rnone_B", b1_valB, 32'h0);
        edge_cycle();
        idle_wr();
        #1;
        chk("byp0_post", b0_valA, 32'h55);
        wb_dstE = 8'h06; wb_valE = 32'h1;
        wb_dstM = 8'h06; wb_valM = 32'h2;
        rd(8'h06, 8'h06);
        chk("byp_mprio", b1_valA, 32'h2);
        chk("byp_mprio0", b0_valB, 32'h0);
        idle_wr();

        // 5: stalled writeback writes nothing and bypasses nothing
        wb_stall = 1'b1;
        wb_dstE  = 8'h01; wb_valE = 32'hFFFF_FFFF;
        rd(8'h0f, 8'h01);
        chk("stall_byp", b1_valB, 32'h0);
        edge_cycle();
        idle_wr();
        rd(8'h01, 8'h01);
        chk("stall_reg1", b1_valA, 32'h0);

        // 6: reset beats a pending write
        wb_dstE = 8'h05; wb_valE = 32'hAA;
        edge_cycle();
        idle_wr();
        rd(8'h05, 8'h05);
        chk("reg5_aa", b1_valA, 32'hAA);
        rst     = 1'b0;
        wb_dstE = 8'h05; wb_valE = 32'h77;
        rd(8'h05, 8'h05);
        chk("rst_nobyp", b1_valA, 32'hAA);
        edge_cycle();
        rst = 1'b1;
        idle_wr();
        rd(8'h05, 8'h04);
        chk("rst_reg5", b1_valA, 32'h0);
        chk("rst_reg4", b1_valB, 32'h100);
        rd(8'h00, 8'h03);
        chk("rst_reg0", b0_valA, 32'h0);
        chk("rst_reg3", b0_valB, 32'h0);

        // invalid / RNONE destinations are dropped
        wb_dstE = 8'h09; wb_valE = 32'h1234;
        wb_dstM = 8'h0f; wb_valM = 32'h5678;
        rd(8'h01, 8'h07);
        chk("inv_nobyp1", b1_valA, 32'h0);
        chk("inv_nobyp7", b1_valB, 32'h0);
        edge_cycle();
        idle_wr();
        rd(8'h01, 8'h07);
        chk("inv_reg1", b1_valA, 32'h0);
        chk("inv_reg7", b1_valB, 32'h0);
        rd(8'h09, 8'h04);
        chk("inv_rd9", b1_valA, 32'h0);
        chk("inv_reg4", b0_valB, 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
